// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer for the 6-stage RV32 pipeline
// Merges load-use, mul/div and memory stalls; issues flush/redirect; watchdog for stuck stalls.
module pipe_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_STALL  = 1024,
   parameter int CNT_WIDTH  = 11
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stallreq_id_i,
   input  logic                  stallreq_mem_i,
   input  logic                  md_req_i,
   input  logic                  md_done_i,
   input  logic                  jump_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   output logic [5:0]            stall_o,
   output logic                  flush_o,
   output logic                  redirect_o,
   output logic [ADDR_WIDTH-1:0] redirect_addr_o,
   output logic                  md_start_o,
   output logic                  md_busy_o,
   output logic                  timeout_o
);

   typedef enum logic {RUN, MD_BUSY} state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_STALL);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_STALL - 1);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
   logic                 timeout_q, timeout_d;

   logic md_stall;
   logic stalled;

   always_comb begin
      md_stall = ((state_q == RUN) && md_req_i) || ((state_q == MD_BUSY) && !md_done_i);

      stall_o = 6'b000000;
      if (stallreq_mem_i)
         stall_o = 6'b011111;
      else if (md_stall)
         stall_o = 6'b001111;
      else if (stallreq_id_i && !jump_i)
         stall_o = 6'b000111;
      if (rst_i)
         stall_o = 6'b000000;

      // EXE advances whenever its own stall bit is clear; a held jump fires then, exactly once.
      redirect_o      = !rst_i && jump_i && !stall_o[3];
      flush_o         = redirect_o;
      redirect_addr_o = redirect_o ? jump_addr_i : '0;
      md_start_o      = !rst_i && (state_q == RUN) && md_req_i && !stallreq_mem_i;

      state_d = state_q;
      if (state_q == RUN && md_req_i && !stallreq_mem_i)
         state_d = MD_BUSY;
      else if (state_q == MD_BUSY && md_done_i)
         state_d = RUN;

      stalled   = (stall_o != 6'b000000);
      wd_cnt_d  = '0;
      if (stalled)
         wd_cnt_d = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
      timeout_d = timeout_q || (stalled && wd_cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RUN;
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign md_busy_o = (state_q == MD_BUSY);
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stallreq_id_i, stallreq_mem_i, md_req_i, md_done_i, jump_i;
   logic [31:0] jump_addr_i;
   logic [5:0]  stall_o;
   logic        flush_o, redirect_o, md_start_o, md_busy_o, timeout_o;
   logic [31:0] redirect_addr_o;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.ADDR_WIDTH(32), .MAX_STALL(8), .CNT_WIDTH(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .stallreq_id_i(stallreq_id_i), .stallreq_mem_i(stallreq_mem_i),
      .md_req_i(md_req_i), .md_done_i(md_done_i),
      .jump_i(jump_i), .jump_addr_i(jump_addr_i),
      .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
      .redirect_addr_o(redirect_addr_o), .md_start_o(md_start_o),
      .md_busy_o(md_busy_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic drive(input logic id, input logic mem, input logic mreq,
                        input logic mdone, input logic jmp, input logic [31:0] addr);
      stallreq_id_i  = id;
      stallreq_mem_i = mem;
      md_req_i       = mreq;
      md_done_i      = mdone;
      jump_i         = jmp;
      jump_addr_i    = addr;
      @(negedge clk_i);
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive(1, 1, 1, 1, 1, 32'hdead_beef);
         checks++;
         if (stall_o !== 6'b0 || flush_o !== 1'b0 || md_start_o !== 1'b0 ||
             redirect_o !== 1'b0 || redirect_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs c%0d: stall=%b flush=%b start=%b redir=%b addr=%h, want all 0",
                     c, stall_o, flush_o, md_start_o, redirect_o, redirect_addr_o);
         end
         next_cycle();
      end
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (md_busy_o !== 1'b0 || timeout_o !== 1'b0 || stall_o !== 6'b0) begin
         errors++;
         $display("FAIL reset_release: busy=%b timeout=%b stall=%b, want 0 0 000000",
                  md_busy_o, timeout_o, stall_o);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      drive(1, 0, 0, 0, 0, 32'h0);
      checks++;
      if (stall_o !== 6'b000111 || flush_o !== 1'b0) begin
         errors++;
         $display("FAIL load_use_stall: stall=%b flush=%b, want 000111 0", stall_o, flush_o);
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (stall_o !== 6'b0) begin
         errors++;
         $display("FAIL load_use_release: stall=%b, want 000000", stall_o);
      end
      next_cycle();
      drive(1, 0, 0, 0, 1, 32'h0000_0040);
      checks++;
      if (stall_o !== 6'b0 || flush_o !== 1'b1 || redirect_o !== 1'b1 ||
          redirect_addr_o !== 32'h0000_0040) begin
         errors++;
         $display("FAIL load_use_jump: stall=%b flush=%b redir=%b addr=%h, want 000000 1 1 00000040",
                  stall_o, flush_o, redirect_o, redirect_addr_o);
      end
      next_cycle();
   endtask

   task automatic test_muldiv();
      for (int c = 0; c <= 6; c++) begin
         logic [5:0] exp_stall;
         logic       exp_start, exp_busy;
         exp_stall = (c <= 4) ? 6'b001111 : 6'b000000;
         exp_start = (c == 0);
         exp_busy  = (c >= 1 && c <= 5);
         drive(0, 0, (c <= 5), (c == 5), 0, 32'h0);
         checks++;
         if (stall_o !== exp_stall || md_start_o !== exp_start || md_busy_o !== exp_busy) begin
            errors++;
            $display("FAIL muldiv c%0d: stall=%b start=%b busy=%b, want %b %b %b",
                     c, stall_o, md_start_o, md_busy_o, exp_stall, exp_start, exp_busy);
         end
         next_cycle();
      end
   endtask

   task automatic test_mem_over_md();
      for (int c = 0; c <= 5; c++) begin
         logic [5:0] exp_stall;
         logic       exp_start, exp_busy;
         exp_stall = (c <= 2) ? 6'b011111 : (c == 3) ? 6'b001111 : 6'b000000;
         exp_start = (c == 3);
         exp_busy  = (c == 4);
         drive(0, (c <= 2), (c <= 4), (c == 4), 0, 32'h0);
         checks++;
         if (stall_o !== exp_stall || md_start_o !== exp_start || md_busy_o !== exp_busy) begin
            errors++;
            $display("FAIL mem_over_md c%0d: stall=%b start=%b busy=%b, want %b %b %b",
                     c, stall_o, md_start_o, md_busy_o, exp_stall, exp_start, exp_busy);
         end
         next_cycle();
      end
   endtask

   task automatic test_deferred_jump();
      int flushes = 0;
      for (int c = 0; c <= 4; c++) begin
         logic        exp_fl;
         logic [31:0] exp_addr;
         exp_fl   = (c == 3);
         exp_addr = exp_fl ? 32'h0000_0100 : 32'h0;
         drive(0, (c <= 2), 0, 0, (c <= 3), 32'h0000_0100);
         if (flush_o === 1'b1) flushes++;
         checks++;
         if (flush_o !== exp_fl || redirect_o !== exp_fl || redirect_addr_o !== exp_addr) begin
            errors++;
            $display("FAIL deferred_jump c%0d: flush=%b redir=%b addr=%h, want %b %b %h",
                     c, flush_o, redirect_o, redirect_addr_o, exp_fl, exp_fl, exp_addr);
         end
         next_cycle();
      end
      checks++;
      if (flushes != 1) begin
         errors++;
         $display("FAIL deferred_jump_count: flushes=%0d, want 1", flushes);
      end
   endtask

   task automatic test_watchdog();
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < 7; c++) begin
            drive(0, 1, 0, 0, 0, 32'h0);
            next_cycle();
         end
         drive(0, 0, 0, 0, 0, 32'h0);
         checks++;
         if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_burst7 b%0d: timeout=%b, want 0", b, timeout_o);
         end
         next_cycle();
      end
      for (int c = 0; c < 8; c++) begin
         drive(0, 1, 0, 0, 0, 32'h0);
         checks++;
         if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_early c%0d: timeout=%b, want 0", c, timeout_o);
         end
         next_cycle();
      end
      for (int c = 8; c < 12; c++) begin
         drive(0, 0, 0, 0, 0, 32'h0);
         checks++;
         if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_sticky c%0d: timeout=%b, want 1", c, timeout_o);
         end
         next_cycle();
      end
      rst_i = 1'b1;
      drive(0, 0, 0, 0, 0, 32'h0);
      next_cycle();
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL watchdog_reset_clear: timeout=%b, want 0", timeout_o);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_md();
      drive(0, 0, 1, 0, 0, 32'h0);
      next_cycle();
      drive(0, 0, 1, 0, 0, 32'h0);
      checks++;
      if (md_busy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_md_busy: busy=%b, want 1", md_busy_o);
      end
      next_cycle();
      rst_i = 1'b1;
      drive(0, 0, 1, 0, 0, 32'h0);
      next_cycle();
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (md_busy_o !== 1'b0 || md_start_o !== 1'b0 || stall_o !== 6'b0) begin
         errors++;
         $display("FAIL reset_mid_md_abandon: busy=%b start=%b stall=%b, want 0 0 000000",
                  md_busy_o, md_start_o, stall_o);
      end
      next_cycle();
   endtask

   initial begin
      rst_i = 1'b1;
      drive(0, 0, 0, 0, 0, 32'h0);
      next_cycle();
      test_reset();
      test_load_use();
      test_muldiv();
      test_mem_over_md();
      test_deferred_jump();
      test_watchdog();
      test_reset_mid_md();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
